// File: rtl/waveform_capture.sv
// Discriminator-triggered ADC capture: a circular pre-trigger buffer plus a post buffer,
// read out over a byte-wide UART handshake as a framed, timestamped record.
module waveform_capture #(
  parameter int ADC_WIDTH    = 12,
  parameter int PRE_SAMPLES  = 4,
  parameter int POST_SAMPLES = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 disc_trig,
  input  logic                 byte_ready,
  output logic [7:0]           byte_to_send,
  output logic                 byte_en,
  output logic                 trig_out,
  output logic                 busy,
  output logic [7:0]           dropped
);

  localparam int PW = (PRE_SAMPLES > 1) ? $clog2(PRE_SAMPLES) : 1;
  localparam int QW = (POST_SAMPLES > 1) ? $clog2(POST_SAMPLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_SAMPLES - 1);
  localparam logic [QW-1:0] POST_LAST = QW'(POST_SAMPLES - 1);
  localparam logic [9:0]    LAST_IDX  = 10'(5 + 2 * (PRE_SAMPLES + POST_SAMPLES));
  localparam logic [9:0]    PRE_CNT   = 10'(PRE_SAMPLES);

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_READOUT} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [31:0]     cyc_q, cyc_d, ts_q, ts_d;
  logic [PW-1:0]   wptr_q, wptr_d, fill_cnt_q, fill_cnt_d, wptr_inc_s;
  logic [QW-1:0]   post_cnt_q, post_cnt_d;
  logic [9:0]      idx_q, idx_d;
  logic            need_low_q, need_low_d;
  logic            byte_en_q, byte_en_d, trig_out_q, trig_out_d, busy_q, busy_d;
  logic [7:0]      byte_q, byte_d, dropped_q, dropped_d;
  logic            trig_ev_s, pre_we_s, post_we_s;

  logic [ADC_WIDTH-1:0] pre_buf  [PRE_SAMPLES];
  logic [ADC_WIDTH-1:0] post_buf [POST_SAMPLES];

  logic [9:0]    rel_s, sidx_s;
  logic [PW:0]   psum_raw_s, psum_s;
  logic [QW-1:0] qidx_s;
  logic [15:0]   samp_s;
  logic [7:0]    cur_byte_s;

  assign trig_ev_s = sync2_q & ~edge_q;

  // Record byte for the current readout index; the oldest pre sample sits at the write pointer.
  always_comb begin
    rel_s      = idx_q - 10'd5;
    sidx_s     = {1'b0, rel_s[9:1]};
    psum_raw_s = {1'b0, wptr_q} + (PW+1)'(sidx_s);
    psum_s     = (psum_raw_s >= (PW+1)'(PRE_SAMPLES)) ? psum_raw_s - (PW+1)'(PRE_SAMPLES) : psum_raw_s;
    qidx_s     = QW'(sidx_s - PRE_CNT);
    if (sidx_s < PRE_CNT) begin
      samp_s = 16'(pre_buf[psum_s[PW-1:0]]);
    end else begin
      samp_s = 16'(post_buf[qidx_s]);
    end
    case (idx_q)
      10'd0:   cur_byte_s = 8'hA5;
      10'd1:   cur_byte_s = ts_q[31:24];
      10'd2:   cur_byte_s = ts_q[23:16];
      10'd3:   cur_byte_s = ts_q[15:8];
      10'd4:   cur_byte_s = ts_q[7:0];
      default: begin
        if (idx_q == LAST_IDX) begin
          cur_byte_s = 8'h5A;
        end else if (rel_s[0] == 1'b0) begin
          cur_byte_s = samp_s[15:8];
        end else begin
          cur_byte_s = samp_s[7:0];
        end
      end
    endcase
  end

  // Next-state logic for the capture FSM, trigger path, counters and byte handshake.
  always_comb begin
    state_d    = state_q;
    sync1_d    = disc_trig;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    cyc_d      = cyc_q + 32'd1;
    ts_d       = ts_q;
    wptr_d     = wptr_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    byte_en_d  = 1'b0;
    trig_out_d = 1'b0;
    pre_we_s   = 1'b0;
    post_we_s  = 1'b0;
    need_low_d = byte_ready ? need_low_q : 1'b0;
    wptr_inc_s = (wptr_q == PRE_LAST) ? PW'(0) : wptr_q + PW'(1);

    if (trig_ev_s && (state_q != S_ARMED) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end

    case (state_q)
      S_FILL: begin
        if (adc_valid) begin
          pre_we_s = 1'b1;
          wptr_d   = wptr_inc_s;
          if (fill_cnt_q == PRE_LAST) begin
            state_d    = S_ARMED;
            fill_cnt_d = PW'(0);
          end else begin
            fill_cnt_d = fill_cnt_q + PW'(1);
          end
        end else begin
          fill_cnt_d = fill_cnt_q;
        end
      end
      S_ARMED: begin
        // A sample arriving with the trigger edge still belongs to the pre-trigger history.
        if (adc_valid) begin
          pre_we_s = 1'b1;
          wptr_d   = wptr_inc_s;
        end else begin
          wptr_d = wptr_q;
        end
        if (trig_ev_s) begin
          ts_d       = cyc_q;
          trig_out_d = 1'b1;
          post_cnt_d = QW'(0);
          state_d    = S_POST;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_POST: begin
        if (adc_valid) begin
          post_we_s = 1'b1;
          if (post_cnt_q == POST_LAST) begin
            post_cnt_d = QW'(0);
            idx_d      = 10'd0;
            state_d    = S_READOUT;
          end else begin
            post_cnt_d = post_cnt_q + QW'(1);
          end
        end else begin
          post_cnt_d = post_cnt_q;
        end
      end
      S_READOUT: begin
        // need_low forces a low-then-high on byte_ready between consecutive strobes.
        if (byte_ready && !need_low_q) begin
          byte_en_d  = 1'b1;
          byte_d     = cur_byte_s;
          need_low_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d      = 10'd0;
            wptr_d     = PW'(0);
            fill_cnt_d = PW'(0);
            state_d    = S_FILL;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end else begin
          byte_en_d = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase

    busy_d = (state_d == S_POST) || (state_d == S_READOUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      cyc_q      <= 32'd0;
      ts_q       <= 32'd0;
      wptr_q     <= PW'(0);
      fill_cnt_q <= PW'(0);
      post_cnt_q <= QW'(0);
      idx_q      <= 10'd0;
      need_low_q <= 1'b0;
      byte_en_q  <= 1'b0;
      trig_out_q <= 1'b0;
      busy_q     <= 1'b0;
      byte_q     <= 8'h00;
      dropped_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      cyc_q      <= cyc_d;
      ts_q       <= ts_d;
      wptr_q     <= wptr_d;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      idx_q      <= idx_d;
      need_low_q <= need_low_d;
      byte_en_q  <= byte_en_d;
      trig_out_q <= trig_out_d;
      busy_q     <= busy_d;
      byte_q     <= byte_d;
      dropped_q  <= dropped_d;
    end
  end

  // Sample buffers carry no reset; stale contents are never read out.
  always_ff @(posedge clk) begin
    if (pre_we_s) begin
      pre_buf[wptr_q] <= adc_data;
    end
    if (post_we_s) begin
      post_buf[post_cnt_q] <= adc_data;
    end
  end

  assign byte_to_send = byte_q;
  assign byte_en      = byte_en_q;
  assign trig_out     = trig_out_q;
  assign busy         = busy_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Scoreboard bench for waveform_capture: expected record bytes are queued when a trigger
// is driven and compared as the DUT strobes them out through a modelled UART.
module tb_waveform_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] adc_data = 12'd0;
  logic        adc_valid = 1'b1;
  logic        disc_trig = 1'b0;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_to_send;
  logic        byte_en;
  logic        trig_out;
  logic        busy;
  logic [7:0]  dropped;

  always #5 clk = ~clk;

  waveform_capture #(.ADC_WIDTH(12), .PRE_SAMPLES(4), .POST_SAMPLES(12)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .disc_trig(disc_trig), .byte_ready(byte_ready), .byte_to_send(byte_to_send),
    .byte_en(byte_en), .trig_out(trig_out), .busy(busy), .dropped(dropped)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          rec_bytes = 0;
  int          trig_pulses = 0;
  int          rdy_cnt = 0;
  bit          hold = 1'b0;
  bit          hold_chk = 1'b0;
  bit          const_mode = 1'b0;
  logic [31:0] cyc_m = 32'd0;
  logic [7:0]  bp_byte;
  int          bp_count;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference cycle counter: value the DUT counter holds before each edge.
  always @(posedge clk) cyc_m <= reset ? 32'd0 : cyc_m + 32'd1;

  // ADC source: ramp, or a constant pattern for byte-order checks.
  always @(negedge clk) adc_data = const_mode ? 12'hABC : adc_data + 12'd1;

  // Output monitor and UART model: ready drops after each strobe and returns ~10 cycles later.
  always @(negedge clk) begin
    if (trig_out) trig_pulses++;
    if (byte_en) begin
      check_val("en_ready", 32'(byte_ready), 32'd1);
      if (hold_chk) check_val("bp_en", 32'(byte_en), 32'd0);
      rec_bytes++;
      if (exp_q.size() == 0) check_val("extra_byte", 32'(byte_to_send), 32'h100);
      else check_val("byte", 32'(byte_to_send), 32'(exp_q.pop_front()));
      rdy_cnt = 11;
    end
    if (rdy_cnt > 0) rdy_cnt--;
    byte_ready = (rdy_cnt == 0) && !hold;
  end

  task automatic push_record(input logic [31:0] ts, input logic [11:0] v1);
    logic [11:0] v;
    exp_q.push_back(8'hA5);
    exp_q.push_back(ts[31:24]);
    exp_q.push_back(ts[23:16]);
    exp_q.push_back(ts[15:8]);
    exp_q.push_back(ts[7:0]);
    for (int i = 0; i < 16; i++) begin
      v = const_mode ? 12'hABC : v1 - 12'd1 + 12'(i);
      exp_q.push_back({4'h0, v[11:8]});
      exp_q.push_back(v[7:0]);
    end
    exp_q.push_back(8'h5A);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rec_bytes = 0;
    trig_pulses = 0;
  endtask

  task automatic fire(input int hi, input int lo);
    @(negedge clk);
    #1;
    disc_trig = 1'b1;
    repeat (hi) @(negedge clk);
    disc_trig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Accepted trigger: the edge lands two clocks after first sampling, so the timestamp is +2.
  task automatic capture(input bit timed);
    @(negedge clk);
    #1;
    push_record(cyc_m + 32'd2, adc_data);
    disc_trig = 1'b1;
    if (timed) begin
      @(posedge clk);
      @(posedge clk);
      #1 check_val("trig_edge2", 32'(trig_out), 32'd0);
      @(posedge clk);
      #1 check_val("trig_edge3", 32'(trig_out), 32'd1);
      check_val("busy_post", 32'(busy), 32'd1);
      @(posedge clk);
      #1 check_val("trig_edge4", 32'(trig_out), 32'd0);
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    disc_trig = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("rec_drain", 32'(exp_q.size()), 32'd0);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int want, input int budget);
    int n = 0;
    while (rec_bytes < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(rec_bytes >= want), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_byte_en", 32'(byte_en), 32'd0);
    check_val("rst_trig_out", 32'(trig_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dropped", 32'(dropped), 32'd0);
    check_val("rst_byte", 32'(byte_to_send), 32'd0);

    // Trigger while still filling: dropped, no pulse, no record.
    reset = 1'b0;
    disc_trig = 1'b1;
    repeat (5) @(negedge clk);
    disc_trig = 1'b0;
    repeat (5) @(negedge clk);
    check_val("early_dropped", 32'(dropped), 32'd1);
    check_val("early_trig", 32'(trig_pulses), 32'd0);
    check_val("early_bytes", 32'(rec_bytes), 32'd0);
    check_val("early_busy", 32'(busy), 32'd0);

    // Basic capture on a ramp.
    repeat (5) @(negedge clk);
    capture(1'b1);
    wait_drain(2000);
    check_val("basic_len", 32'(rec_bytes), 32'd38);
    check_val("basic_pulses", 32'(trig_pulses), 32'd1);
    check_val("basic_dropped", 32'(dropped), 32'd1);
    check_val("basic_busy", 32'(busy), 32'd0);

    // Triggers during readout, then saturation under backpressure.
    do_reset();
    repeat (8) @(negedge clk);
    capture(1'b0);
    wait_bytes("rd_start", 2, 1000);
    repeat (3) fire(2, 4);
    repeat (4) @(negedge clk);
    check_val("busy_drop3", 32'(dropped), 32'd3);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold_chk = 1'b1;
    bp_byte = byte_to_send;
    bp_count = rec_bytes;
    repeat (300) fire(2, 2);
    repeat (5) @(negedge clk);
    check_val("bp_count", 32'(rec_bytes), 32'(bp_count));
    check_val("bp_hold_byte", 32'(byte_to_send), 32'(bp_byte));
    check_val("drop_sat", 32'(dropped), 32'd255);
    check_val("bp_busy", 32'(busy), 32'd1);
    hold_chk = 1'b0;
    hold = 1'b0;
    wait_drain(2000);
    check_val("busy_rec_len", 32'(rec_bytes), 32'd38);
    check_val("busy_pulses", 32'(trig_pulses), 32'd1);

    // Byte order with a constant 0xABC sample.
    const_mode = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    capture(1'b0);
    wait_drain(2000);
    check_val("abc_len", 32'(rec_bytes), 32'd38);
    const_mode = 1'b0;

    // Reset in the middle of readout, then a fresh full record.
    do_reset();
    repeat (8) @(negedge clk);
    capture(1'b0);
    wait_bytes("rd10", 10, 1000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_byte_en", 32'(byte_en), 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_byte", 32'(byte_to_send), 32'd0);
    check_val("mid_dropped", 32'(dropped), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    rec_bytes = 0;
    trig_pulses = 0;
    repeat (8) @(negedge clk);
    capture(1'b0);
    wait_drain(2000);
    check_val("fresh_len", 32'(rec_bytes), 32'd38);
    check_val("fresh_pulses", 32'(trig_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/waveform_capture.md
WAVEFORM_CAPTURE -- requirements
Module: waveform_capture

Interface
REQ-001 The block SHALL have parameter ADC_WIDTH, default 12, giving the ADC sample width in bits (legal range 1..16).
REQ-002 The block SHALL have parameter PRE_SAMPLES, default 4, giving the number of pre-trigger samples kept (legal range 1..64).
REQ-003 The block SHALL have parameter POST_SAMPLES, default 12, giving the number of samples captured after the trigger (legal range 1..256).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- adc_data  in  ADC_WIDTH  ADC sample.
- adc_valid  in  1  sample strobe; adc_data is taken on a clk edge where this is high.
- disc_trig  in  1  asynchronous discriminator trigger.
- byte_ready  in  1  UART idle / can accept a byte.
- byte_to_send  out  8  byte presented to the UART.
- byte_en  out  1  one-cycle byte strobe.
- trig_out  out  1  one-cycle pulse for each accepted trigger.
- busy  out  1  high in POST and READOUT.
- dropped  out  8  count of triggers rejected while not ARMED.

Function
REQ-005 disc_trig SHALL pass through a 2-flop synchronizer followed by a rising-edge detect register; a trigger event is a synchronized 0->1 edge.
REQ-006 A free-running 32-bit cycle counter SHALL increment every clk and wrap from 0xFFFFFFFF to 0.
REQ-007 State machine states SHALL be FILL, ARMED, POST and READOUT, with these transitions:
- FILL -> ARMED: once PRE_SAMPLES valid samples have been written since entering FILL.
- ARMED -> POST: on a trigger event.
- POST -> READOUT: once POST_SAMPLES valid samples have been written.
- READOUT -> FILL: after the last byte is accepted.
REQ-008 In FILL and ARMED, valid samples SHALL be written to a circular pre-trigger buffer of depth PRE_SAMPLES; the write pointer wraps from PRE_SAMPLES-1 to 0.
REQ-009 On a trigger accepted in ARMED:
- the cycle counter value SHALL be latched as the timestamp;
- trig_out SHALL pulse high for exactly one cycle, on the third rising clk edge after disc_trig is first sampled high;
- the state SHALL become POST.
REQ-010 In POST, valid samples SHALL be stored in a post buffer of depth POST_SAMPLES; the pre buffer is frozen.
REQ-011 A trigger event in FILL, POST or READOUT SHALL:
- increment dropped, saturating at 255;
- produce no trig_out pulse;
- leave the state unchanged.
REQ-012 READOUT SHALL emit one record of 6+2*(PRE_SAMPLES+POST_SAMPLES) bytes (38 at defaults), in this order:
- 0xA5;
- timestamp, 4 bytes, MSB first;
- pre samples oldest first, then post samples in capture order; each sample is 2 bytes, MSB first, zero-extended to 16 bits;
- 0x5A.
REQ-013 Byte handshake:
- byte_en SHALL be high for exactly one cycle, only on a cycle where byte_ready is high.
- byte_to_send SHALL be stable from the byte_en cycle until byte_ready next reads high.
- After each strobe, the next byte SHALL NOT be issued until byte_ready has been sampled low at least once and then high again.
REQ-014 If adc_valid and a trigger event occur in the same cycle in ARMED, that sample SHALL be written to the pre buffer and SHALL NOT count toward POST_SAMPLES.
REQ-015 adc_valid SHALL be ignored during READOUT; on re-entry to FILL, the pre buffer SHALL refill from zero count, and earlier contents are never read out.
REQ-016 busy SHALL be high exactly while the state is POST or READOUT.

Reset
REQ-017 While reset is high at a clk edge, the block SHALL return to the following state, including mid-POST or mid-READOUT, with any partial record abandoned:
- state FILL;
- cycle counter, timestamp, pointers, sample counters and dropped all 0;
- synchronizer flops 0;
- byte_en, trig_out and busy 0;
- byte_to_send 0x00.
REQ-018 Buffer contents SHALL NOT require reset.

Verification
REQ-019 Directed bench scenarios (defaults; adc_valid held high; byte_ready model drops 1 cycle after byte_en and returns 10 cycles later):
- Basic capture: feed ramp samples 1,2,3,...; raise disc_trig for 5 cycles once ARMED -> exactly 38 bytes; first 0xA5, last 0x5A; 16 consecutive ramp values with the post set starting after the sample written in the edge cycle; trig_out pulses once, 3 clk edges after disc_trig is first sampled high.
- Early trigger: trigger in FILL 2 cycles after reset -> dropped=1, no trig_out, no record, state reaches ARMED after 4 samples.
- Busy trigger: 3 triggers during READOUT -> dropped=3, single record output; 300 more triggers -> dropped saturates at 255.
- Byte ordering: ADC_WIDTH=12, sample 0xABC -> bytes 0x0A, 0xBC; timestamp 0x01020304 -> 0x01,0x02,0x03,0x04.
- Reset mid-readout: assert reset after byte 10 -> byte_en stays 0, busy 0 the cycle after; the next trigger after refill yields a complete fresh 38-byte record.
- Backpressure: hold byte_ready low for 200 cycles mid-record -> no byte_en during the hold, no byte lost or duplicated, byte_to_send unchanged.
